// File: rtl/sync_fifo_16to8_pkg.sv
// Shared definitions for the 16-to-8 unpacking FIFO and the 8-to-16 path models.
package fifo_pkg;

    // Default word depth of the FIFO.
    localparam int FIFO_DEPTH_DEF = 128;

    // High byte of each word leaves the FIFO first.
    localparam bit BYTE_ORDER_MSB_FIRST = 1'b1;

    // Occupancy between two free-running pointers of the given width.
    // The subtraction wraps modulo 2^width.
    function automatic logic [31:0] occupancy(input logic [31:0] head,
                                              input logic [31:0] tail,
                                              input int unsigned width);
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return (head - tail) & mask;
    endfunction

endpackage

// File: rtl/sync_fifo_16to8_if.sv
// Bus between a word producer / byte consumer and the 16-to-8 FIFO.
interface sync_fifo_16to8_if
    import fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [15:0]       wr_data;
    logic              wr_en;
    logic              rd_en;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;
    logic [ADDR_W:0]   wr_data_count;
    logic [ADDR_W+1:0] rd_data_count;

    // FIFO side.
    modport slave (
        input  wr_data, wr_en, rd_en,
        output rd_data, rd_valid, full, empty, overflow, underflow,
               wr_data_count, rd_data_count
    );

    // User side.
    modport master (
        output wr_data, wr_en, rd_en,
        input  rd_data, rd_valid, full, empty, overflow, underflow,
               wr_data_count, rd_data_count
    );

endinterface

// File: rtl/sync_fifo_16to8_sdp_ram_16.sv
// Simple dual-port word store: synchronous write, asynchronous read.
module sdp_ram_16 #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [15:0]       rdata
);

    logic [15:0] mem [DEPTH];

    // Store the incoming word; contents are deliberately left uninitialised.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_16to8.sv
// Single-clock FIFO taking 16-bit words and delivering them as a byte stream.
module sync_fifo_16to8
    import fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    sync_fifo_16to8_if.slave    bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int WCW    = ADDR_W + 1;
    localparam int RCW    = ADDR_W + 2;

    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W+1:0] rd_ptr;
    logic [ADDR_W:0]   rd_word;
    logic [WCW-1:0]    wr_count;
    logic [RCW-1:0]    rd_count;
    logic              full;
    logic              empty;
    logic              wr_accept;
    logic              rd_accept;
    logic [15:0]       ram_rdata;
    logic [7:0]        byte_sel;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic              overflow;
    logic              underflow;

    // Counts and flags come only from registered pointers. A word slot stays
    // counted until both of its bytes have been read.
    assign rd_word   = rd_ptr[ADDR_W+1:1];
    assign wr_count  = WCW'(occupancy(32'(wr_ptr), 32'(rd_word), WCW));
    assign rd_count  = RCW'(occupancy(32'({wr_ptr, 1'b0}), 32'(rd_ptr), RCW));
    assign full      = (wr_count == WCW'(DEPTH));
    assign empty     = (rd_count == '0);

    // Each side is judged against the flags as they stood before the edge,
    // so there is no fall-through and no write into a slot freed this cycle.
    assign wr_accept = bus.wr_en && !full;
    assign rd_accept = bus.rd_en && !empty;

    sdp_ram_16 #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (sys_clk),
        .we    (wr_accept),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (bus.wr_data),
        .raddr (rd_word[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    // Pick the byte addressed by the low bit of the byte pointer.
    assign byte_sel = (rd_ptr[0] ^ !BYTE_ORDER_MSB_FIRST) ? ram_rdata[7:0]
                                                          : ram_rdata[15:8];

    // Pointer, output-register and status-pulse update.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= byte_sel;
            end
            rd_valid  <= rd_accept;
            overflow  <= bus.wr_en && full;
            underflow <= bus.rd_en && empty;
        end
    end

    assign bus.rd_data       = rd_data;
    assign bus.rd_valid      = rd_valid;
    assign bus.full          = full;
    assign bus.empty         = empty;
    assign bus.overflow      = overflow;
    assign bus.underflow     = underflow;
    assign bus.wr_data_count = wr_count;
    assign bus.rd_data_count = rd_count;

endmodule
